// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial A+B+cin through one full_adder cell, WIDTH clocks per result.
// Define BIT_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic carry,
  output logic sum
);
  assign sum   = A ^ B ^ C;
  assign carry = (A & B) | (C & (A ^ B));
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef BIT_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_busy, r_done, r_cout;
  logic             w_c, w_s;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             r_ovf;
  assign ovf = r_ovf;
`endif
  full_adder u_fa (.A(r_a[0]), .B(r_b[0]), .C(r_carry), .carry(w_c), .sum(w_s));
  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        RUN: begin
          r_carry <= w_c;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_cout  <= w_c;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            // r_carry is the carry into the MSB on this edge
            r_ovf   <= r_carry ^ w_c;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed and random checks of bit_serial_adder against an arithmetic model.
module tb_bit_serial_adder;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] e_s;
  logic         e_c, e_o;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum),
`ifdef BIT_SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int unsigned t;
    int sx, sy, st;
    t   = int'(x) + int'(y) + int'(c);
    e_s = t[W-1:0];
    e_c = t[W];
    sx  = int'(x) - (x[W-1] ? (1 << W) : 0);
    sy  = int'(y) - (y[W-1] ? (1 << W) : 0);
    st  = sx + sy + int'(c);
    e_o = (st > (1 << (W - 1)) - 1) || (st < -(1 << (W - 1)));
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    model(x, y, c);
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic expect_run(input string tag, input int glitch);
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    chk({tag, "_done0"}, {31'd0, done}, 32'd0);
    for (int k = 1; k < W; k++) begin
      if (k == glitch) begin
        start = 1'b1; a = 8'h55;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, e_s});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e_c});
`ifdef BIT_SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e_o});
`endif
  endtask

  task automatic expect_idle(input string tag);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_rest"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hold"}, {24'd0, sum}, {24'd0, e_s});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    issue(8'h3C, 8'h0A, 1'b0); expect_run("basic", 0); expect_idle("basic");
    chk("basic_const", {24'd0, sum}, 32'h46);
    issue(8'hFF, 8'h01, 1'b0); expect_run("wrap", 0); expect_idle("wrap");
    chk("wrap_cout", {31'd0, cout}, 32'd1);
    issue(8'h7F, 8'h01, 1'b0); expect_run("sovf", 0); expect_idle("sovf");
    chk("sovf_const", {24'd0, sum}, 32'h80);
    issue(8'hFF, 8'hFF, 1'b1); expect_run("fullc", 0); expect_idle("fullc");

    issue(8'h10, 8'h20, 1'b0); expect_run("ignore", 3);
    chk("ignore_const", {24'd0, sum}, 32'h30);
    issue(8'h01, 8'h02, 1'b0); expect_run("b2b", 0); expect_idle("b2b");
    chk("b2b_const", {24'd0, sum}, 32'h03);

    issue(8'hAA, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_sum", {24'd0, sum}, 32'd0);
    chk("mrst_cout", {31'd0, cout}, 32'd0);
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk); #1;
      chk("mrst_nodone", {31'd0, done | busy}, 32'd0);
    end
    issue(8'h01, 8'h01, 1'b0); expect_run("after_rst", 0); expect_idle("after_rst");

    for (int n = 0; n < 24; n++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      expect_run("rand", (n % 3 == 0) ? int'($urandom_range(1, W - 1)) : 0);
      if (n % 2 == 0) expect_idle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Multi-bit adder that computes A + B + cin one bit per clock, LSB first.
- Each cycle it feeds one bit of A, one bit of B and a registered carry into a single full_adder instance, then captures that instance's carry and sum outputs.
- Sits directly around the full_adder cell: it supplies the cell's inputs (A, B, C) and consumes its outputs (carry, sum).
- Trades latency for area in narrow datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new addition; sampled on the rising clk edge
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; sum and cout are valid
- sum  output  WIDTH  result, A+B+cin modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset: on a rising edge with rst=1:
  - state <= IDLE.
  - busy, done, cout and sum all 0.
  - Internal shift registers, carry register and bit counter cleared.
  - rst has priority over start and over any in-flight operation. The operation is abandoned and no done pulse is produced.
- States:
  - IDLE: start=1 is accepted. Load opA<=a, opB<=b, carry<=cin, count<=0, busy<=1. Go to RUN.
  - RUN, one bit per edge:
    - full_adder inputs: A=opA[0], B=opB[0], C=carry.
    - carry <= full_adder carry.
    - sum register shifts right with full_adder sum entering at bit WIDTH-1.
    - opA and opB shift right by 1.
    - count <= count+1.
    - On the edge where count==WIDTH-1: cout <= full_adder carry, busy<=0, done<=1, go to DONE.
  - DONE: lasts exactly one cycle; done=1 during it. Next edge: done<=0.
    - If start=1 on that edge, accept it exactly as in IDLE and go to RUN.
    - Otherwise go to IDLE.
- Latency:
  - start accepted on edge E0.
  - busy=1 from after E0 through E0+WIDTH.
  - done=1 in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after acceptance.
  - Back-to-back throughput: one result per WIDTH+1 cycles.
- start while in RUN is ignored; it is not queued.
- Changes on a, b or cin after acceptance have no effect on the operation in flight.
- sum and cout hold their last result until the next accepted start or a reset.
  - They are not guaranteed meaningful while busy=1: sum is a partial shift value.
  - cout updates only on the final RUN edge.
- Arithmetic is unsigned modulo 2^WIDTH. The carry chain is exactly the ripple order bit 0 to bit WIDTH-1.
- done and busy are never high in the same cycle.

Optional Feature:
- Macro: BIT_SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (output, 1 bit): two's-complement signed overflow.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Captured on the final RUN edge alongside cout.
  - Reset value 0; held with sum until the next accepted start.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic add, WIDTH=8: a=0x3C, b=0x0A, cin=0, start for 1 cycle.
  - Required: busy high 8 cycles, then done for 1 cycle.
  - sum=0x46, cout=0, ovf=0.
- Wrap-around: a=0xFF, b=0x01, cin=0.
  - Required: sum=0x00, cout=1, ovf=0.
- Signed overflow: a=0x7F, b=0x01, cin=0.
  - Required: sum=0x80, cout=0, ovf=1.
- Full carry-in: a=0xFF, b=0xFF, cin=1.
  - Required: sum=0xFF, cout=1, ovf=0.
- Busy and back-to-back starts, in two parts:
  - Start a=0x10, b=0x20. Pulse start again with a=0x55 during the 3rd RUN cycle. Required: ignored; result sum=0x30.
  - Hold start=1 through DONE with a=0x01, b=0x02. Required: new run begins; next done gives sum=0x03.
- Reset mid-operation: start a=0xAA, b=0x55, assert rst for 1 cycle on the 4th RUN cycle.
  - Required: next cycle busy=0, done=0, sum=0x00, cout=0; no done pulse follows.
  - A subsequent start a=0x01, b=0x01 yields sum=0x02 after 8 cycles.
